// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - N-key debouncer with press/release strobes, long-press and auto-repeat
module key_debounce_array #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 120000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 3000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_in,
    input  logic [N_KEYS-1:0] i_repeat_en,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_neg,
    output logic [N_KEYS-1:0] o_pos,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HC_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HC_W   = $clog2(HC_MAX + 1);

    localparam logic              RELEASED = (ACTIVE_LOW != 0);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HC_W-1:0]   HC_LONG  = HC_W'(LONG_CYCLES);
    localparam logic [HC_W-1:0]   HC_REP   = HC_W'(REPEAT_CYCLES);
    localparam logic [HC_W-1:0]   REP_LAST = HC_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_t;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DEB_W-1:0]       r_deb;
        logic                   r_level;
        logic                   r_neg;
        logic                   r_pos;
        logic                   r_long;
        logic                   r_repeat;
        logic [HC_W-1:0]        r_hc;
        hold_state_t            r_state;

        logic                   w_pressed;
        logic                   w_diff;
        logic                   w_toggle;
        logic                   w_rise;
        logic                   w_fall;
        hold_state_t            w_state_nxt;
        logic [HC_W-1:0]        w_hc_nxt;
        logic                   w_long_nxt;
        logic                   w_repeat_nxt;

        always_comb begin
            w_pressed = r_sync[SYNC_STAGES-1] ^ RELEASED;
            w_diff    = (w_pressed != r_level);
            w_toggle  = w_diff && (r_deb == DEB_LAST);
            w_rise    = w_toggle && !r_level;
            w_fall    = w_toggle && r_level;
        end

        // A release always wins over any pending long/repeat strobe.
        always_comb begin
            w_state_nxt  = r_state;
            w_hc_nxt     = r_hc;
            w_long_nxt   = 1'b0;
            w_repeat_nxt = 1'b0;
            if (w_fall) begin
                w_state_nxt = ST_IDLE;
                w_hc_nxt    = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_hc_nxt = '0;
                        if (w_rise) begin
                            w_state_nxt = ST_HOLD;
                            w_hc_nxt    = HC_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (r_hc == HC_LONG) begin
                            w_long_nxt  = 1'b1;
                            w_hc_nxt    = '0;
                            w_state_nxt = ST_REPEAT;
                        end else begin
                            w_hc_nxt = r_hc + HC_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        // The long/repeat strobe cycle itself is count zero of the next period.
                        if (r_hc >= REP_LAST) begin
                            if (i_repeat_en[k]) begin
                                w_repeat_nxt = 1'b1;
                                w_hc_nxt     = '0;
                            end else begin
                                w_hc_nxt = HC_REP;
                            end
                        end else begin
                            w_hc_nxt = r_hc + HC_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_hc_nxt    = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_sync   <= {SYNC_STAGES{RELEASED}};
                r_deb    <= '0;
                r_level  <= 1'b0;
                r_neg    <= 1'b0;
                r_pos    <= 1'b0;
                r_long   <= 1'b0;
                r_repeat <= 1'b0;
                r_hc     <= '0;
                r_state  <= ST_IDLE;
            end else begin
                r_sync   <= {r_sync[SYNC_STAGES-2:0], i_in[k]};
                r_deb    <= (!w_diff || w_toggle) ? '0 : r_deb + DEB_W'(1);
                r_level  <= r_level ^ w_toggle;
                r_neg    <= w_rise;
                r_pos    <= w_fall;
                r_long   <= w_long_nxt;
                r_repeat <= w_repeat_nxt;
                r_hc     <= w_hc_nxt;
                r_state  <= w_state_nxt;
            end
        end

        assign o_level[k]  = r_level;
        assign o_neg[k]    = r_neg;
        assign o_pos[k]    = r_pos;
        assign o_long[k]   = r_long;
        assign o_repeat[k] = r_repeat;
    end

endmodule
